// File: rtl/nonce_sequencer_if.sv
// Handshake bundle between the nonce sequencer, its header/target source and the hash core.
interface nonce_sequencer_if #(
  parameter int BYTE = 8
);
  logic                 start;
  logic [BYTE*12-1:0]   data_in;
  logic [7:0]           target;
  logic [BYTE*16-1:0]   hash_block;
  logic                 hash_start;
  logic                 hash_done;
  logic [BYTE*3-1:0]    hash_in;
  logic                 finished;
  logic [31:0]          nonce_out;
  logic                 exhausted;

  // Environment side: drives the search request and the hash core results.
  modport master (
    output start, data_in, target, hash_done, hash_in,
    input  hash_block, hash_start, finished, nonce_out, exhausted
  );

  // Sequencer side.
  modport slave (
    input  start, data_in, target, hash_done, hash_in,
    output hash_block, hash_start, finished, nonce_out, exhausted
  );
endinterface

// File: rtl/nonce_sequencer.sv
// Nonce search control: appends a 32-bit nonce to a latched 12-byte header,
// launches one hash per nonce and stops on the first hash whose two upper
// bytes are both below the target, or on exhaustion at NONCE_MAX.
module nonce_sequencer #(
  parameter int          BYTE       = 8,
  parameter logic [31:0] NONCE_INIT = 32'h0,
  parameter logic [31:0] NONCE_MAX  = 32'hFFFF_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  nonce_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t               state_q;
  logic [BYTE*12-1:0]   data_q;
  logic [7:0]           target_q;
  logic [31:0]          nonce_q;
  logic [BYTE*3-1:0]    hash_q;
  logic [BYTE*16-1:0]   hash_block_q;
  logic                 hash_start_q;
  logic                 finished_q;
  logic [31:0]          nonce_out_q;
  logic                 exhausted_q;

  logic                 accept_d;
  logic                 pass_d;

  // start only counts in the resting states; mid-search it is ignored.
  always_comb begin
    accept_d = bus.start &&
               (state_q == S_IDLE || state_q == S_DONE || state_q == S_FAIL);
    // Low hash byte is intentionally not part of the difficulty test.
    pass_d   = (hash_q[BYTE*3-1 -: 8] < target_q) &&
               (hash_q[BYTE*2-1 -: 8] < target_q);
  end

  // Search FSM with registered outputs; finished/exhausted rise one cycle
  // after entering DONE/FAIL so nonce_out is only non-zero alongside finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      target_q     <= '0;
      nonce_q      <= '0;
      hash_q       <= '0;
      hash_block_q <= '0;
      hash_start_q <= 1'b0;
      finished_q   <= 1'b0;
      nonce_out_q  <= '0;
      exhausted_q  <= 1'b0;
    end else begin
      hash_start_q <= 1'b0;
      if (accept_d) begin
        data_q      <= bus.data_in;
        target_q    <= bus.target;
        nonce_q     <= NONCE_INIT;
        finished_q  <= 1'b0;
        nonce_out_q <= '0;
        exhausted_q <= 1'b0;
        state_q     <= S_LOAD;
      end else begin
        case (state_q)
          S_LOAD: begin
            hash_block_q <= {data_q, nonce_q};
            hash_start_q <= 1'b1;
            state_q      <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.hash_done) begin
              hash_q  <= bus.hash_in;
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (pass_d) begin
              state_q <= S_DONE;
            end else if (nonce_q == NONCE_MAX) begin
              state_q <= S_FAIL;
            end else begin
              nonce_q <= nonce_q + 32'd1;
              state_q <= S_LOAD;
            end
          end
          S_DONE: begin
            finished_q  <= 1'b1;
            nonce_out_q <= nonce_q;
          end
          S_FAIL: begin
            exhausted_q <= 1'b1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.hash_block = hash_block_q;
  assign bus.hash_start = hash_start_q;
  assign bus.finished   = finished_q;
  assign bus.nonce_out  = nonce_out_q;
  assign bus.exhausted  = exhausted_q;

endmodule

// File: tb/tb_nonce_sequencer.sv
// Bench for nonce_sequencer: two instances (default range, and a 3-nonce range
// ending at NONCE_MAX) driven by a cycle-exact hash core model.
module tb_nonce_sequencer;

  localparam logic [31:0] INIT_B = 32'hFFFF_FFFD;
  localparam logic [31:0] MAX_B  = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  nonce_sequencer_if ifa ();
  nonce_sequencer_if ifb ();

  nonce_sequencer u_a (.clk(clk), .reset(reset), .bus(ifa));
  nonce_sequencer #(.NONCE_INIT(INIT_B), .NONCE_MAX(MAX_B))
    u_b (.clk(clk), .reset(reset), .bus(ifb));

  logic         start_r [2];
  logic [95:0]  din_r   [2];
  logic [7:0]   tgt_r   [2];
  logic         hdone_r [2];
  logic [23:0]  hin_r   [2];
  logic [127:0] hb      [2];
  logic         hs      [2];
  logic         fin     [2];
  logic [31:0]  nout    [2];
  logic         exh     [2];

  assign ifa.start = start_r[0];  assign ifb.start = start_r[1];
  assign ifa.data_in = din_r[0];  assign ifb.data_in = din_r[1];
  assign ifa.target = tgt_r[0];   assign ifb.target = tgt_r[1];
  assign ifa.hash_done = hdone_r[0]; assign ifb.hash_done = hdone_r[1];
  assign ifa.hash_in = hin_r[0];  assign ifb.hash_in = hin_r[1];
  assign hb[0] = ifa.hash_block;  assign hb[1] = ifb.hash_block;
  assign hs[0] = ifa.hash_start;  assign hs[1] = ifb.hash_start;
  assign fin[0] = ifa.finished;   assign fin[1] = ifb.finished;
  assign nout[0] = ifa.nonce_out; assign nout[1] = ifb.nonce_out;
  assign exh[0] = ifa.exhausted;  assign exh[1] = ifb.exhausted;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outs(input int w, input string tag);
    chk({tag, "_hb"}, hb[w], 128'h0);
    chk({tag, "_hs"}, hs[w], 1'b0);
    chk({tag, "_fin"}, fin[w], 1'b0);
    chk({tag, "_nout"}, nout[w], 32'h0);
    chk({tag, "_exh"}, exh[w], 1'b0);
  endtask

  // Model of one full search: hl[i] is the hash the core returns for the
  // i-th attempt; lat<=0 picks a random core latency per attempt.
  task automatic search(input int w, input logic [95:0] hdr, input logic [7:0] tgt,
                        input logic [23:0] hl[$], input int lat, input bit spur);
    logic [31:0] n;
    logic [31:0] nmax;
    logic [23:0] h;
    int          l;
    bit          pass;
    n    = (w == 0) ? 32'h0 : INIT_B;
    nmax = (w == 0) ? 32'hFFFF_FFFF : MAX_B;
    @(negedge clk);
    din_r[w] = hdr; tgt_r[w] = tgt; start_r[w] = 1'b1;
    @(negedge clk);
    start_r[w] = 1'b0;
    din_r[w] = {$urandom, $urandom, $urandom};
    tgt_r[w] = 8'($urandom);
    @(negedge clk);
    chk("fin_clr", fin[w], 1'b0);
    chk("exh_clr", exh[w], 1'b0);
    for (int i = 0; i < 64; i++) begin
      chk("hs_pulse", hs[w], 1'b1);
      chk("hblk", hb[w], {hdr, n});
      if (hs[w] !== 1'b1) return;
      l = (lat > 0) ? lat : int'($urandom_range(1, 5));
      repeat (l) @(negedge clk);
      chk("hs_low", hs[w], 1'b0);
      chk("hblk_hold", hb[w], {hdr, n});
      h = (i < hl.size()) ? hl[i] : 24'hFFFFFF;
      hdone_r[w] = 1'b1; hin_r[w] = h;
      if (spur && i == 0) begin
        start_r[w] = 1'b1; din_r[w] = ~hdr;
      end
      @(negedge clk);
      hdone_r[w] = 1'b0; hin_r[w] = 24'($urandom); start_r[w] = 1'b0;
      @(negedge clk);
      chk("fin_early", fin[w], 1'b0);
      chk("nout_early", nout[w], 32'h0);
      @(negedge clk);
      pass = (h[23:16] < tgt) && (h[15:8] < tgt);
      if (pass) begin
        chk("finished", fin[w], 1'b1);
        chk("nonce_out", nout[w], n);
        chk("exh_on_pass", exh[w], 1'b0);
        chk("hs_after_pass", hs[w], 1'b0);
        return;
      end else if (n == nmax) begin
        chk("exhausted", exh[w], 1'b1);
        chk("fin_on_exh", fin[w], 1'b0);
        chk("nout_on_exh", nout[w], 32'h0);
        chk("hs_after_exh", hs[w], 1'b0);
        return;
      end
      n = n + 32'd1;
    end
    chk("att_bound", 32'd64, hl.size());
  endtask

  initial begin
    logic [23:0] q[$];
    logic [7:0]  t;
    int          len;
    for (int w = 0; w < 2; w++) begin
      start_r[w] = 1'b0; din_r[w] = '0; tgt_r[w] = '0;
      hdone_r[w] = 1'b0; hin_r[w] = '0;
    end
    repeat (3) @(negedge clk);
    chk_idle_outs(0, "rst_a");
    chk_idle_outs(1, "rst_b");
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outs(0, "post_rst_a");

    // First-try pass with a 4-cycle core.
    q = {24'h1020FF};
    search(0, 96'h397d9f2f40ca9e6c6b1f3324, 8'd150, q, 4, 1'b0);

    // Restart from DONE with a new header; start collides with hash_done in WAIT.
    q = {24'hFF0000, 24'h000000};
    search(0, 96'h3c87edfd24331f6b6c9eca40, 8'd150, q, 0, 1'b1);

    // Multi-try: nonces 0-4 fail, nonce 5 passes.
    q = {24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h059500};
    search(0, 96'h0123456789abcdef01234567, 8'd150, q, 0, 1'b0);

    // Boundary compare: equal to target fails on either byte.
    q = {24'h960000, 24'h009600, 24'h9595FF};
    search(0, 96'hfedcba9876543210fedcba98, 8'd150, q, 1, 1'b0);

    // Exhaustion over the last three nonces.
    q = {24'hFF0000, 24'h00FF00, 24'h969600};
    search(1, 96'h111122223333444455556666, 8'd150, q, 0, 1'b0);

    // Target 0 never passes.
    q = {24'h000000, 24'h000000, 24'h000000};
    search(1, 96'h777788889999aaaabbbbcccc, 8'd0, q, 0, 1'b0);

    // Reset while waiting on the hash core.
    @(negedge clk);
    din_r[0] = 96'hdeadbeefcafef00d12345678; tgt_r[0] = 8'd200; start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    @(negedge clk);
    chk("rw_hs", hs[0], 1'b1);
    #2 reset = 1'b1;
    #1 chk_idle_outs(0, "rw_async");
    @(negedge clk); reset = 1'b0; hdone_r[0] = 1'b1; hin_r[0] = 24'h0;
    @(negedge clk); hdone_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outs(0, "rw_after");

    // Randomized searches.
    for (int r = 0; r < 20; r++) begin
      q = {};
      t = 8'($urandom_range(1, 255));
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len - 1; i++) q.push_back(24'($urandom));
      q.push_back({8'($urandom_range(0, int'(t) - 1)), 8'($urandom_range(0, int'(t) - 1)),
                   8'($urandom)});
      search(0, {$urandom, $urandom, $urandom}, t, q, 0, r[0]);
    end
    for (int r = 0; r < 10; r++) begin
      q = {};
      t = 8'($urandom);
      for (int i = 0; i < 3; i++) q.push_back(24'($urandom));
      search(1, {$urandom, $urandom, $urandom}, t, q, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Outcome flags are mutually exclusive on both instances at all times.
  always @(negedge clk) begin
    if (!reset) begin
      if (fin[0] && exh[0]) chk("fin_exh_a", {fin[0], exh[0]}, 2'b00);
      if (fin[1] && exh[1]) chk("fin_exh_b", {fin[1], exh[1]}, 2'b00);
    end
  end

endmodule
